div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//   Iterative RV32M divider (DIV/DIVU/REM/REMU) producing one quotient bit per cycle.
//   Accepts operands read from the register file in the execute stage.
//   Returns its result directly to the register-file write port as a one-cycle write strobe.
//   Exports the busy flag and the pending destination so hazard logic can stall dependent instructions.
// PARAMETERS
//   XLEN  32  operand/result width; iteration count = XLEN, counter width = $clog2(XLEN)+1
// PORTS
//   clk         in   1     clock, all state updates on posedge
//   rst_n       in   1     asynchronous active-low reset
//   start       in   1     issue request; accepted only when busy==0 && kill==0
//   op          in   2     00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with start
//   rs1_value   in   XLEN  dividend, sampled with start
//   rs2_value   in   XLEN  divisor, sampled with start
//   rd_num      in   5     destination register, sampled with start
//   kill        in   1     pipeline flush; cancels any in-flight operation
//   busy        out  1     high in CALC and DONE
//   pend_num    out  5     latched rd_num while busy; 0 when idle
//   wb_we       out  1     one-cycle write strobe to register-file write port
//   wb_num      out  5     destination register of the write
//   wb_value    out  XLEN  quotient or remainder
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; busy=0, pend_num=0, wb_we=0, wb_num=0, wb_value=0; internal regs cleared.
//   States: IDLE -> CALC -> DONE -> IDLE; IDLE -> DONE for special cases.
//   Issue: start && !busy && !kill at edge T latches op, rd_num, operands and sign info.
//     Normal case: CALC during T+1..T+32 (XLEN cycles), DONE at T+33, IDLE at T+34.
//   start while busy=1: ignored; no queueing, no error.
//   CALC: restoring shift-subtract on unsigned magnitudes.
//     Each cycle: shift remainder left by one and insert the next dividend MSB.
//     Subtract the divisor if the partial remainder >= divisor and set the quotient bit.
//     Decrement the counter; leave CALC when the counter reaches 0.
//   Signed ops (DIV/REM): operands converted to magnitudes at issue.
//     Quotient is negated when the operand signs differ.
//     Remainder takes the sign of the dividend.
//   Special cases, detected at issue; skip CALC and enter DONE at T+1:
//     divisor==0: quotient=all ones (0xFFFFFFFF); remainder=dividend (both signed and unsigned).
//     DIV/REM with dividend=0x80000000, divisor=0xFFFFFFFF: quotient=0x80000000, remainder=0.
//   DONE, one cycle: wb_value=result selected by op; wb_num=latched rd.
//     wb_we=1 unless latched rd==0 (then wb_we=0, cycle timing unchanged).
//   wb_we, wb_num and wb_value are registered outputs. wb_we is 0 in every state except DONE.
//   Outside DONE, wb_value and wb_num hold their last values.
//   pend_num: latched rd in CALC and DONE; 0 in IDLE.
//   kill=1 at any edge: next state=IDLE, busy=0, pend_num=0, wb_we=0.
//     kill takes priority over start and over the DONE writeback.
//     A kill sampled in the DONE cycle does not retract the strobe already presented in that cycle.
//   rst_n asserted mid-operation: immediate return to reset values; no writeback.
// TESTING
//   DIVU 100/7, rd=5 -> busy from T+1; wb_we=1 only at T+33, wb_num=5, wb_value=14; REMU same operands -> 2.
//   DIV -7/2 -> wb_value=0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); REM 7/-2 -> 1.
//   DIVU 5/0 -> 0xFFFFFFFF at T+1; REM 0x80000000/0xFFFFFFFF -> 0 at T+1, busy high one cycle.
//   start pulsed at T+5 during CALC with other operands -> ignored; first result unchanged at T+33.
//   Next start at T+34 -> accepted.
//   kill at T+10 -> busy=0 at T+11, no wb_we ever; start with kill in IDLE -> not accepted.
//   rd_num=0 -> full 33-cycle latency, busy pattern unchanged, wb_we stays 0.
//   rst_n low mid-CALC -> all outputs 0 immediately.

Source files
------------

// File: rtl/div_unit.sv
// Iterative RV32M divider: restoring shift-subtract, one quotient bit per cycle,
// with a registered one-cycle writeback strobe and hazard-visible busy/pending rd.
module div_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1_value,
  input  logic [XLEN-1:0] rs2_value,
  input  logic [4:0]      rd_num,
  input  logic            kill,
  output logic            busy,
  output logic [4:0]      pend_num,
  output logic            wb_we,
  output logic [4:0]      wb_num,
  output logic [XLEN-1:0] wb_value
);

  localparam int unsigned CntW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [XLEN-1:0]   dvd_q;    // dividend bits shift out, quotient bits shift in
  logic [XLEN-1:0]   dvs_q;
  logic [XLEN-1:0]   rem_q;
  logic [4:0]        rd_q;
  logic              sel_rem_q;
  logic              neg_quo_q;
  logic              neg_rem_q;

  logic              rs1_neg, rs2_neg;
  logic [XLEN-1:0]   rs1_mag, rs2_mag;
  logic              div_zero, ovf;
  logic [XLEN-1:0]   special_val;
  logic [XLEN:0]     rem_shift, sub_res;
  logic              ge;
  logic [XLEN-1:0]   rem_n, dvd_n, quo_fin, rem_fin, calc_val;

  always_comb begin
    rs1_neg     = !op[0] && rs1_value[XLEN-1];
    rs2_neg     = !op[0] && rs2_value[XLEN-1];
    rs1_mag     = rs1_neg ? (XLEN'(0) - rs1_value) : rs1_value;
    rs2_mag     = rs2_neg ? (XLEN'(0) - rs2_value) : rs2_value;
    div_zero    = (rs2_value == '0);
    ovf         = !op[0] && (rs1_value == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_value == '1);
    special_val = '0;
    if (div_zero) begin
      special_val = op[1] ? rs1_value : '1;
    end else if (!op[1]) begin
      special_val = {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  always_comb begin
    rem_shift = {rem_q, dvd_q[XLEN-1]};
    sub_res   = rem_shift - {1'b0, dvs_q};
    ge        = !sub_res[XLEN];
    rem_n     = ge ? sub_res[XLEN-1:0] : rem_shift[XLEN-1:0];
    dvd_n     = {dvd_q[XLEN-2:0], ge};
    quo_fin   = neg_quo_q ? (XLEN'(0) - dvd_n) : dvd_n;
    rem_fin   = neg_rem_q ? (XLEN'(0) - rem_n) : rem_n;
    calc_val  = sel_rem_q ? rem_fin : quo_fin;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      rd_q      <= '0;
      sel_rem_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy      <= 1'b0;
      pend_num  <= '0;
      wb_we     <= 1'b0;
      wb_num    <= '0;
      wb_value  <= '0;
    end else begin
      wb_we <= 1'b0;
      if (kill) begin
        state_q  <= StIdle;
        busy     <= 1'b0;
        pend_num <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              rd_q      <= rd_num;
              sel_rem_q <= op[1];
              neg_quo_q <= rs1_neg ^ rs2_neg;
              neg_rem_q <= rs1_neg;
              busy      <= 1'b1;
              pend_num  <= rd_num;
              if (div_zero || ovf) begin
                state_q  <= StDone;
                wb_value <= special_val;
                wb_num   <= rd_num;
                wb_we    <= (rd_num != '0);
              end else begin
                state_q <= StCalc;
                cnt_q   <= CntW'(XLEN);
                dvd_q   <= rs1_mag;
                dvs_q   <= rs2_mag;
                rem_q   <= '0;
              end
            end
          end
          StCalc: begin
            dvd_q <= dvd_n;
            rem_q <= rem_n;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CntW'(1)) begin
              state_q  <= StDone;
              wb_value <= calc_val;
              wb_num   <= rd_q;
              wb_we    <= (rd_q != '0);
            end
          end
          StDone: begin
            state_q  <= StIdle;
            busy     <= 1'b0;
            pend_num <= '0;
          end
          default: begin
            state_q  <= StIdle;
            busy     <= 1'b0;
            pend_num <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed RV32M cases, timing, kill/reset behaviour
// and randomized operations against an arithmetic reference model.
module tb_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1_value;
  logic [31:0] rs2_value;
  logic [4:0]  rd_num;
  logic        kill;
  logic        busy;
  logic [4:0]  pend_num;
  logic        wb_we;
  logic [4:0]  wb_num;
  logic [31:0] wb_value;

  int n_tests = 0;
  int n_fail  = 0;

  div_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .rs1_value (rs1_value),
    .rs2_value (rs2_value),
    .rd_num    (rd_num),
    .kill      (kill),
    .busy      (busy),
    .pend_num  (pend_num),
    .wb_we     (wb_we),
    .wb_num    (wb_num),
    .wb_value  (wb_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero like RV32M.
  function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb;
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return o[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return o[1] ? (a % b) : (a / b);
  endfunction

  function automatic bit is_special(input logic [1:0] o, input logic [31:0] a,
                                    input logic [31:0] b);
    return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Issue one op and check every cycle until the unit is idle again.
  // inject >= 0 pulses a foreign start in that sampled cycle, which must be ignored.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int inject, input string tag);
    int          lat;
    logic [31:0] exp_v;
    lat   = is_special(o, a, b) ? 0 : 32;
    exp_v = ref_res(o, a, b);
    op = o; rs1_value = a; rs2_value = b; rd_num = rd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k <= lat + 1; k++) begin
      chk({tag, ".busy"}, 32'(busy), 32'(k <= lat));
      chk({tag, ".pend"}, 32'(pend_num), (k <= lat) ? 32'(rd) : 32'd0);
      chk({tag, ".we"}, 32'(wb_we), 32'((k == lat) && (rd != 5'd0)));
      if (k == lat) begin
        chk({tag, ".num"}, 32'(wb_num), 32'(rd));
        chk({tag, ".val"}, wb_value, exp_v);
      end
      if (k == inject) begin
        op = 2'b01; rs1_value = 32'd999; rs2_value = 32'd3; rd_num = 5'd9; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (k <= lat) begin
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int          m;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    logic [4:0]  rr;
    rst_n = 1'b0; start = 1'b0; op = '0; rs1_value = '0; rs2_value = '0;
    rd_num = '0; kill = 1'b0;
    #12;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.pend", 32'(pend_num), 32'd0);
    chk("rst.we", 32'(wb_we), 32'd0);
    chk("rst.num", 32'(wb_num), 32'd0);
    chk("rst.val", wb_value, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(2'b01, 32'd100, 32'd7, 5'd5, -1, "divu");
    run_op(2'b11, 32'd100, 32'd7, 5'd5, -1, "remu");
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd6, -1, "div_neg");
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd7, -1, "rem_neg");
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 5'd8, -1, "rem_posneg");
    run_op(2'b01, 32'd5, 32'd0, 5'd3, -1, "divu_zero");
    run_op(2'b10, 32'hFFFF_FFF0, 32'd0, 5'd3, -1, "rem_zero");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, -1, "rem_ovf");
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, -1, "div_ovf");
    run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, -1, "divu_big");
    // Foreign start sampled at T+5, then back-to-back issue at T+34.
    run_op(2'b01, 32'd100, 32'd7, 5'd5, 4, "ignore");
    run_op(2'b00, 32'h8000_0000, 32'd3, 5'd10, -1, "b2b");
    run_op(2'b01, 32'd100, 32'd7, 5'd0, -1, "rd0");

    // Kill sampled at T+10.
    op = 2'b01; rs1_value = 32'd100; rs2_value = 32'd7; rd_num = 5'd5; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    kill = 1'b1;
    @(posedge clk); #1; kill = 1'b0;
    chk("kill.busy", 32'(busy), 32'd0);
    chk("kill.pend", 32'(pend_num), 32'd0);
    m = 0;
    repeat (40) begin @(posedge clk); #1; if (wb_we || busy) m++; end
    chk("kill.quiet", 32'(m), 32'd0);

    // start together with kill in IDLE is not accepted.
    start = 1'b1; kill = 1'b1;
    @(posedge clk); #1; start = 1'b0; kill = 1'b0;
    chk("killstart.busy", 32'(busy), 32'd0);
    m = 0;
    repeat (35) begin @(posedge clk); #1; if (wb_we || busy) m++; end
    chk("killstart.quiet", 32'(m), 32'd0);

    // Asynchronous reset mid-CALC.
    rd_num = 5'd12; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    chk("midrst.pre_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.pend", 32'(pend_num), 32'd0);
    chk("midrst.num", 32'(wb_num), 32'd0);
    chk("midrst.val", wb_value, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    m = 0;
    repeat (40) begin @(posedge clk); #1; if (wb_we || busy) m++; end
    chk("midrst.quiet", 32'(m), 32'd0);

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rr = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, rr, -1, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
